// File: rtl/pulseox_pkg.sv
// AFE4490 register map and read-sequencer state encoding shared by the pulse-ox blocks.
// Constants and types only; no timing and no handshake.
package pulseox_pkg;

    localparam logic [7:0] REG_CONTROL0    = 8'h00;
    localparam logic [7:0] REG_LED2VAL     = 8'h2A;
    localparam logic [7:0] REG_ALED2VAL    = 8'h2B;
    localparam logic [7:0] REG_LED1VAL     = 8'h2C;
    localparam logic [7:0] REG_ALED1VAL    = 8'h2D;
    localparam logic [7:0] REG_LED2ABSVAL  = 8'h2E;
    localparam logic [7:0] REG_LED1ABSVAL  = 8'h2F;

    localparam int NUM_SLOTS = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_PUBLISH = 2'd2
    } rd_state_e;

    // Result registers are contiguous, so slot n lives at LED2VAL + n.
    function automatic logic [7:0] slot_addr(input logic [2:0] idx);
        return REG_LED2VAL + {5'd0, idx};
    endfunction

endpackage

// File: rtl/afe_read_seq_if.sv
// SPI master read handshake: address plus begin pulse out, one-cycle done pulse with data back.
// Pure wiring; the SPI master samples the address on the begin pulse and never stalls it.
interface afe_read_seq_if;
    logic [7:0]  out_addr_r;
    logic        out_r_begin;
    logic [23:0] in_r_data;
    logic        in_r_done;

    modport master (output out_addr_r, output out_r_begin, input in_r_data, input in_r_done);
    modport slave  (input out_addr_r, input out_r_begin, output in_r_data, output in_r_done);
endinterface

// File: rtl/afe_read_seq_rise_detect.sv
// Rising-edge detector: combinational pulse from the input and a registered previous sample.
// Zero latency; the previous-sample reset value decides whether a level held at reset release counts.
module rise_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic prev_q;
    logic prev_d;

    always_comb prev_d = d;

    always_ff @(posedge clk) begin
        if (!rst_n) prev_q <= RST_VAL;
        else        prev_q <= prev_d;
    end

    assign rise = d & ~prev_q;
endmodule

// File: rtl/afe_read_seq.sv
// Per ADC_RDY edge, reads the six AFE result registers and publishes them as one frame.
// out_r_begin 1 cycle after the edge or the previous done; out_valid 2 cycles after the sixth done.
module afe_read_seq
    import pulseox_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic               clk,
    input  logic               in_reset_n,
    input  logic               in_r_enable,
    input  logic               in_adc_rdy,
    afe_read_seq_if.master     spi,
    output logic [23:0]        out_led2,
    output logic [23:0]        out_aled2,
    output logic [23:0]        out_led1,
    output logic [23:0]        out_aled1,
    output logic [23:0]        out_led2abs,
    output logic [23:0]        out_led1abs,
    output logic               out_valid,
    output logic               out_overrun,
    output logic               out_timeout
);
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    logic adc_edge;

    rise_detect #(.RST_VAL(1'b1)) u_rdy_edge (
        .clk   (clk),
        .rst_n (in_reset_n),
        .d     (in_adc_rdy),
        .rise  (adc_edge)
    );

    rd_state_e   state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [23:0] stg_q [NUM_SLOTS];
    logic [23:0] stg_d [NUM_SLOTS];
    logic [23:0] frm_q [NUM_SLOTS];
    logic [23:0] frm_d [NUM_SLOTS];
    logic [7:0]  addr_q, addr_d;
    logic        begin_q, begin_d;
    logic        valid_q, valid_d;
    logic        overrun_q, overrun_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        stg_d     = stg_q;
        frm_d     = frm_q;
        addr_d    = addr_q;
        begin_d   = 1'b0;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (adc_edge && in_r_enable) begin
                    idx_d   = 3'd0;
                    addr_d  = REG_LED2VAL;
                    begin_d = 1'b1;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                overrun_d = adc_edge;
                if (!in_r_enable) begin
                    state_d = ST_IDLE;
                end else if (spi.in_r_done) begin
                    // A done arriving on the timeout cycle still completes the read.
                    stg_d[idx_q] = spi.in_r_data;
                    if (idx_q == 3'd5) begin
                        state_d = ST_PUBLISH;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        addr_d  = slot_addr(idx_q + 3'd1);
                        begin_d = 1'b1;
                        timer_d = '0;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_PUBLISH: begin
                overrun_d = adc_edge;
                if (in_r_enable) begin
                    frm_d   = stg_q;
                    valid_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!in_reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 3'd0;
            timer_q   <= '0;
            stg_q     <= '{default: '0};
            frm_q     <= '{default: '0};
            addr_q    <= 8'h00;
            begin_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            stg_q     <= stg_d;
            frm_q     <= frm_d;
            addr_q    <= addr_d;
            begin_q   <= begin_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign spi.out_addr_r  = addr_q;
    assign spi.out_r_begin = begin_q;

    assign out_led2    = frm_q[0];
    assign out_aled2   = frm_q[1];
    assign out_led1    = frm_q[2];
    assign out_aled1   = frm_q[3];
    assign out_led2abs = frm_q[4];
    assign out_led1abs = frm_q[5];
    assign out_valid   = valid_q;
    assign out_overrun = overrun_q;
    assign out_timeout = timeout_q;
endmodule

// File: tb/tb_afe_read_seq.sv
// Scoreboard bench: expected read addresses and frames are queued with the stimulus,
// a monitor pops and compares them whenever the DUT pulses out_r_begin or out_valid.
module tb_afe_read_seq;
    typedef logic [5:0][23:0] frame_t;

    logic clk = 1'b0;
    logic in_reset_n, in_r_enable, in_adc_rdy;
    logic [23:0] out_led2, out_aled2, out_led1, out_aled1, out_led2abs, out_led1abs;
    logic out_valid, out_overrun, out_timeout;

    afe_read_seq_if spi ();

    afe_read_seq #(.TIMEOUT_CYC(15)) dut (
        .clk         (clk),
        .in_reset_n  (in_reset_n),
        .in_r_enable (in_r_enable),
        .in_adc_rdy  (in_adc_rdy),
        .spi         (spi),
        .out_led2    (out_led2),
        .out_aled2   (out_aled2),
        .out_led1    (out_led1),
        .out_aled1   (out_aled1),
        .out_led2abs (out_led2abs),
        .out_led1abs (out_led1abs),
        .out_valid   (out_valid),
        .out_overrun (out_overrun),
        .out_timeout (out_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_addr[$];
    frame_t     exp_frame[$];

    int begin_cnt = 0, valid_cnt = 0, overrun_cnt = 0, timeout_cnt = 0;
    int done_cnt = 0, reads_total = 0, withhold_n = -1;
    int last_done_cyc = 0, last_begin_cyc = 0;
    int lat_cnt = -1;
    logic [7:0] lat_addr = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic frame_t std_frame();
        frame_t f;
        for (int i = 0; i < 6; i++) f[i] = 24'h100000 + 24'(8'h2A + i);
        return f;
    endfunction

    task automatic push_reads(input int n);
        for (int i = 0; i < n; i++) exp_addr.push_back(8'(8'h2A + i));
    endtask

    task automatic pulse_rdy();
        in_adc_rdy = 1'b1;
        repeat (2) @(negedge clk);
        in_adc_rdy = 1'b0;
        @(negedge clk);
    endtask

    // SPI master model: 3-cycle read latency, returns 0x100000 + address.
    initial begin
        spi.in_r_done = 1'b0;
        spi.in_r_data = 24'h0;
        forever begin
            @(negedge clk);
            spi.in_r_done = 1'b0;
            spi.in_r_data = 24'h0;
            if (lat_cnt == 0) begin
                spi.in_r_done = 1'b1;
                spi.in_r_data = 24'h100000 + 24'(lat_addr);
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (lat_cnt >= 0) lat_cnt--;
            if (spi.out_r_begin === 1'b1) begin
                reads_total++;
                if (reads_total == withhold_n) lat_cnt = -1;
                else begin
                    lat_addr = spi.out_addr_r;
                    lat_cnt  = 2;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every output strobe.
    initial begin
        frame_t f;
        logic [7:0] a;
        forever begin
            @(negedge clk);
            if (out_overrun === 1'b1) overrun_cnt++;
            if (out_timeout === 1'b1) begin
                timeout_cnt++;
                chk("timeout_latency", 32'(cyc - last_begin_cyc), 32'd15);
            end
            if (spi.out_r_begin === 1'b1) begin
                begin_cnt++;
                last_begin_cyc = cyc;
                if (exp_addr.size() == 0) chk("unexpected_r_begin", 32'(spi.out_addr_r), 32'hFF);
                else begin
                    a = exp_addr.pop_front();
                    chk("read_addr", 32'(spi.out_addr_r), 32'(a));
                    if (a != 8'h2A) chk("turnaround", 32'(cyc - last_done_cyc), 32'd1);
                end
            end
            if (out_valid === 1'b1) begin
                valid_cnt++;
                chk("valid_latency", 32'(cyc - last_done_cyc), 32'd2);
                if (exp_frame.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else begin
                    f = exp_frame.pop_front();
                    chk("led2",    32'(out_led2),    32'(f[0]));
                    chk("aled2",   32'(out_aled2),   32'(f[1]));
                    chk("led1",    32'(out_led1),    32'(f[2]));
                    chk("aled1",   32'(out_aled1),   32'(f[3]));
                    chk("led2abs", 32'(out_led2abs), 32'(f[4]));
                    chk("led1abs", 32'(out_led1abs), 32'(f[5]));
                end
            end
        end
    end

    initial begin
        int v0, b0, o0, t0, d0;
        in_reset_n  = 1'b0;
        in_r_enable = 1'b1;
        in_adc_rdy  = 1'b1;
        repeat (4) @(negedge clk);
        in_reset_n = 1'b1;
        repeat (6) @(negedge clk);

        // Level high at reset release must not start a frame.
        chk("reset_no_begin", 32'(begin_cnt), 32'd0);
        chk("reset_addr", 32'(spi.out_addr_r), 32'h0);
        chk("reset_led2", 32'(out_led2), 32'h0);
        chk("reset_led1abs", 32'(out_led1abs), 32'h0);
        chk("reset_strobes", {29'd0, out_valid, out_overrun, out_timeout}, 32'd0);
        in_adc_rdy = 1'b0;
        repeat (3) @(negedge clk);

        // Normal frame.
        push_reads(6);
        exp_frame.push_back(std_frame());
        v0 = valid_cnt;
        in_adc_rdy = 1'b1;
        @(negedge clk);
        chk("first_begin_latency", {31'd0, spi.out_r_begin}, 32'd1);
        @(negedge clk);
        in_adc_rdy = 1'b0;
        for (int i = 0; i < 200 && valid_cnt == v0; i++) @(negedge clk);
        chk("frame1_valid", 32'(valid_cnt), 32'(v0 + 1));
        chk("frame1_reads", 32'(begin_cnt), 32'd6);
        repeat (5) @(negedge clk);

        // Second edge mid-frame: overrun, frame unaffected.
        push_reads(6);
        exp_frame.push_back(std_frame());
        v0 = valid_cnt; b0 = begin_cnt; o0 = overrun_cnt; d0 = done_cnt;
        pulse_rdy();
        for (int i = 0; i < 100 && done_cnt < d0 + 3; i++) @(negedge clk);
        pulse_rdy();
        for (int i = 0; i < 200 && valid_cnt == v0; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk("overrun_pulse", 32'(overrun_cnt), 32'(o0 + 1));
        chk("overrun_reads", 32'(begin_cnt), 32'(b0 + 6));
        chk("overrun_valid", 32'(valid_cnt), 32'(v0 + 1));

        // Fourth read never answered: timeout, previous frame retained.
        push_reads(4);
        v0 = valid_cnt; t0 = timeout_cnt;
        withhold_n = reads_total + 4;
        pulse_rdy();
        for (int i = 0; i < 300 && timeout_cnt == t0; i++) @(negedge clk);
        chk("timeout_pulse", 32'(timeout_cnt), 32'(t0 + 1));
        repeat (5) @(negedge clk);
        chk("timeout_no_valid", 32'(valid_cnt), 32'(v0));
        chk("timeout_keep_led2", 32'(out_led2), 32'h10002A);
        chk("timeout_keep_aled1", 32'(out_aled1), 32'h10002D);
        withhold_n = -1;
        push_reads(6);
        exp_frame.push_back(std_frame());
        pulse_rdy();
        for (int i = 0; i < 200 && valid_cnt == v0; i++) @(negedge clk);
        chk("after_timeout_valid", 32'(valid_cnt), 32'(v0 + 1));
        repeat (5) @(negedge clk);

        // Enable dropped after the second read completes.
        push_reads(3);
        v0 = valid_cnt; b0 = begin_cnt; t0 = timeout_cnt; d0 = done_cnt;
        pulse_rdy();
        for (int i = 0; i < 100 && done_cnt < d0 + 2; i++) @(negedge clk);
        @(negedge clk);
        in_r_enable = 1'b0;
        repeat (30) @(negedge clk);
        chk("drop_reads", 32'(begin_cnt), 32'(b0 + 3));
        chk("drop_no_valid", 32'(valid_cnt), 32'(v0));
        chk("drop_no_timeout", 32'(timeout_cnt), 32'(t0));

        // Edges while disabled are ignored entirely.
        b0 = begin_cnt; o0 = overrun_cnt;
        pulse_rdy();
        pulse_rdy();
        repeat (10) @(negedge clk);
        chk("disabled_no_begin", 32'(begin_cnt), 32'(b0));
        chk("disabled_no_overrun", 32'(overrun_cnt), 32'(o0));
        chk("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
        chk("frame_queue_empty", 32'(exp_frame.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
